// File: rtl/seq_alu_if.sv
// seq_alu controller/display bus.
// Inputs come from the controller, results go to the display.
interface seq_alu_if #(
  parameter int W = 8
);
  logic           start_i;
  logic [2:0]     op_i;
  logic           sign_i;
  logic           chain_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           busy_o;
  logic           done_o;
  logic [2*W-1:0] res_o;
  logic           err_o;

  modport master (
    output start_i, op_i, sign_i, chain_i, a_i, b_i,
    input  busy_o, done_o, res_o, err_o
  );

  modport slave (
    input  start_i, op_i, sign_i, chain_i, a_i, b_i,
    output busy_o, done_o, res_o, err_o
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: one-cycle add/sub/logic, iterative mul/div/mod.
// Magnitudes are processed unsigned; signs are applied in FIX.
module seq_alu #(
  parameter int W = 8
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           busy_q, done_q, err_q;
  logic [2*W-1:0] res_q;
  logic [2:0]     op_q;
  logic           sign_q, sa_q, sb_q, bz_q;
  logic [W-1:0]   a_q, m_q, lo;
  logic [W:0]     hi;

  function automatic logic [2*W-1:0] ext(
    input logic [W-1:0] x,
    input logic         s
  );
    return s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
  endfunction

  logic [W-1:0]   a_sel, ma, mb;
  logic           multi;
  logic [2*W-1:0] quick;

  assign a_sel = bus.chain_i ? res_q[W-1:0] : bus.a_i;
  assign ma = (bus.sign_i && a_sel[W-1]) ? -a_sel : a_sel;
  assign mb = (bus.sign_i && bus.b_i[W-1]) ? -bus.b_i : bus.b_i;
  assign multi = (bus.op_i == OP_MUL) || (bus.op_i == OP_DIV) ||
                 (bus.op_i == OP_MOD);

  always_comb begin
    quick = '0;
    unique case (1'b1)
      (bus.op_i == OP_ADD):
        quick = ext(a_sel, bus.sign_i) + ext(bus.b_i, bus.sign_i);
      (bus.op_i == OP_SUB):
        quick = ext(a_sel, bus.sign_i) - ext(bus.b_i, bus.sign_i);
      (bus.op_i == OP_AND): quick = ext(a_sel & bus.b_i, bus.sign_i);
      (bus.op_i == OP_OR):  quick = ext(a_sel | bus.b_i, bus.sign_i);
      (bus.op_i == OP_XOR): quick = ext(a_sel ^ bus.b_i, bus.sign_i);
      default: quick = '0;
    endcase
  end

  // hi:lo is the product (MUL) or remainder:quotient (DIV/MOD)
  logic [W:0] mul_sum, div_r, div_d;
  logic       div_ge;

  assign mul_sum = hi + {1'b0, m_q & {W{lo[0]}}};
  assign div_r   = {hi[W-1:0], lo[W-1]};
  assign div_ge  = div_r >= {1'b0, m_q};
  assign div_d   = div_r - {1'b0, m_q};

  logic [2*W-1:0] prod, quo, rem, fix_res;
  logic           neg;

  assign prod = {hi[W-1:0], lo};
  assign quo  = {{W{1'b0}}, lo};
  assign rem  = {{W{1'b0}}, hi[W-1:0]};
  assign neg  = sa_q ^ sb_q;

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      (op_q == OP_MUL): fix_res = neg ? -prod : prod;
      (op_q == OP_DIV): fix_res = bz_q ? '1 : (neg ? -quo : quo);
      default:
        fix_res = bz_q ? ext(a_q, sign_q) : (sa_q ? -rem : rem);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      res_q  <= '0;
      op_q   <= OP_ADD;
      sign_q <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      bz_q   <= 1'b0;
      a_q    <= '0;
      m_q    <= '0;
      lo     <= '0;
      hi     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i && multi) begin
            state  <= CALC;
            cnt    <= '0;
            busy_q <= 1'b1;
            op_q   <= bus.op_i;
            sign_q <= bus.sign_i;
            sa_q   <= bus.sign_i & a_sel[W-1];
            sb_q   <= bus.sign_i & bus.b_i[W-1];
            bz_q   <= bus.b_i == '0;
            a_q    <= a_sel;
            hi     <= '0;
            lo     <= (bus.op_i == OP_MUL) ? mb : ma;
            m_q    <= (bus.op_i == OP_MUL) ? ma : mb;
          end else if (bus.start_i) begin
            res_q  <= quick;
            err_q  <= 1'b0;
            done_q <= 1'b1;
          end
        end
        CALC: begin
          if (op_q == OP_MUL) begin
            hi <= {1'b0, mul_sum[W:1]};
            lo <= {mul_sum[0], lo[W-1:1]};
          end else begin
            hi <= div_ge ? div_d : div_r;
            lo <= {lo[W-2:0], div_ge};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          res_q  <= fix_res;
          err_q  <= bz_q && (op_q != OP_MUL);
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.res_o  = res_q;
  assign bus.err_o  = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=8).
// Reference model uses plain signed integer arithmetic.
module tb_seq_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_if #(.W(W)) bus ();
  seq_alu #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_res;

  function automatic void model(
    input  logic [2:0]     op,
    input  logic           s,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] r,
    output logic           e
  );
    longint av, bv, x;
    logic [W-1:0] lg;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    e = 1'b0;
    x = 0;
    lg = '0;
    case (op)
      3'd0: x = av + bv;
      3'd1: x = av - bv;
      3'd2: x = av * bv;
      3'd3: if (b == 0) begin e = 1'b1; x = -1; end else x = av / bv;
      3'd4: if (b == 0) begin e = 1'b1; x = av; end else x = av % bv;
      default: begin
        if (op == 3'd5) lg = a & b;
        else if (op == 3'd6) lg = a | b;
        else lg = a ^ b;
        x = s ? longint'($signed(lg)) : longint'(lg);
      end
    endcase
    r = x[2*W-1:0];
  endfunction

  // Drives one op, waits for done, collects what the DUT did.
  task automatic run_op(
    input  logic [2:0]     op,
    input  logic           s,
    input  logic           c,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  bit             poke,
    output logic [2*W-1:0] r,
    output logic           e,
    output logic [2*W-1:0] xr,
    output logic           xe,
    output int             lat,
    output int             xlat,
    output int             bcnt,
    output int             dcnt,
    output int             ovl
  );
    logic [W-1:0] aeff;
    aeff = c ? last_res[W-1:0] : a;
    model(op, s, aeff, b, xr, xe);
    last_res = xr;
    xlat = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? W + 1 : 0;
    @(negedge clk);
    bus.op_i = op; bus.sign_i = s; bus.chain_i = c;
    bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.a_i = W'($urandom);
    bus.b_i = W'($urandom);
    bus.chain_i = 1'b0;
    lat = 0; bcnt = 0; ovl = 0;
    while (!bus.done_o && lat < 40) begin
      if (bus.busy_o) bcnt++;
      bus.start_i = (poke && lat == 3);
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start_i = 1'b0;
    if (bus.done_o && bus.busy_o) ovl++;
    r = bus.res_o;
    e = bus.err_o;
    dcnt = bus.done_o ? 1 : 0;
    repeat (W + 3) begin
      @(posedge clk);
      #1;
      if (bus.done_o) dcnt++;
      if (bus.done_o && bus.busy_o) ovl++;
    end
  endtask

  logic [2*W-1:0] r, xr;
  logic e, xe;
  int lat, xlat, bcnt, dcnt, ovl;

  task automatic test_reset;
    rst = 1'b0;
    bus.start_i = 1'b0; bus.op_i = '0; bus.sign_i = 1'b0;
    bus.chain_i = 1'b0; bus.a_i = '0; bus.b_i = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl busy=%b done=%b exp 0 0",
               bus.busy_o, bus.done_o);
    end
    checks++;
    if (bus.res_o !== 16'h0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_data res=%h err=%b exp 0000 0",
               bus.res_o, bus.err_o);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd0, 1'b0, 1'b1, 8'd77, 8'd9, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'd9) begin
      errors++;
      $display("FAIL chain_after_reset res=%h exp 0009", r);
    end
  endtask

  task automatic test_add;
    logic [2:0] ops[5];
    ops = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
    run_op(3'd0, 1'b0, 1'b0, 8'd200, 8'd100, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'h012C || e !== 1'b0) begin
      errors++;
      $display("FAIL add_dir res=%h err=%b exp 012c 0", r, e);
    end
    checks++;
    if (lat !== 0 || bcnt !== 0 || dcnt !== 1) begin
      errors++;
      $display("FAIL add_timing lat=%0d busy=%0d dones=%0d exp 0 0 1",
               lat, bcnt, dcnt);
    end
    for (int i = 0; i < 20; i++) begin
      run_op(ops[$urandom_range(0, 4)], 1'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), 0,
             r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
      checks++;
      if (r !== xr || e !== xe || lat !== xlat || bcnt !== 0) begin
        errors++;
        $display("FAIL quick_rand res=%h err=%b lat=%0d exp %h %b %0d",
                 r, e, lat, xr, xe, xlat);
      end
    end
  endtask

  task automatic test_mul;
    run_op(3'd2, 1'b1, 1'b0, 8'hFD, 8'd5, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'hFFF1 || e !== 1'b0) begin
      errors++;
      $display("FAIL mul_dir res=%h err=%b exp fff1 0", r, e);
    end
    checks++;
    if (lat !== 9 || bcnt !== 9 || dcnt !== 1 || ovl !== 0) begin
      errors++;
      $display("FAIL mul_timing lat=%0d busy=%0d dones=%0d ovl=%0d exp 9 9 1 0",
               lat, bcnt, dcnt, ovl);
    end
  endtask

  task automatic test_div;
    run_op(3'd3, 1'b1, 1'b0, 8'hF9, 8'd2, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'hFFFD) begin
      errors++;
      $display("FAIL div_neg res=%h exp fffd", r);
    end
    run_op(3'd4, 1'b1, 1'b0, 8'hF9, 8'd2, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'hFFFF) begin
      errors++;
      $display("FAIL mod_neg res=%h exp ffff", r);
    end
    run_op(3'd3, 1'b1, 1'b0, 8'h80, 8'hFF, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'h0080 || e !== 1'b0 || lat !== 9) begin
      errors++;
      $display("FAIL div_min res=%h err=%b lat=%0d exp 0080 0 9", r, e, lat);
    end
  endtask

  task automatic test_div_zero;
    run_op(3'd3, 1'b0, 1'b0, 8'd5, 8'd0, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'hFFFF || e !== 1'b1 || lat !== 9) begin
      errors++;
      $display("FAIL div_zero res=%h err=%b lat=%0d exp ffff 1 9", r, e, lat);
    end
    run_op(3'd4, 1'b0, 1'b0, 8'd5, 8'd0, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'h0005 || e !== 1'b1) begin
      errors++;
      $display("FAIL mod_zero res=%h err=%b exp 0005 1", r, e);
    end
    run_op(3'd0, 1'b0, 1'b0, 8'd1, 8'd1, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'h0002 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_clear res=%h err=%b exp 0002 0", r, e);
    end
  endtask

  task automatic test_chain;
    run_op(3'd0, 1'b0, 1'b0, 8'd3, 8'd4, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'h0007) begin
      errors++;
      $display("FAIL chain_seed res=%h exp 0007", r);
    end
    run_op(3'd2, 1'b0, 1'b1, 8'd99, 8'd6, 1,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'h002A || dcnt !== 1 || lat !== 9) begin
      errors++;
      $display("FAIL chain_mul res=%h dones=%0d lat=%0d exp 002a 1 9",
               r, dcnt, lat);
    end
  endtask

  task automatic test_reset_mid;
    int dn;
    @(negedge clk);
    bus.op_i = 3'd2; bus.sign_i = 1'b0; bus.chain_i = 1'b0;
    bus.a_i = 8'd7; bus.b_i = 8'd9; bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    last_res = '0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
        bus.res_o !== 16'h0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b res=%h err=%b exp 0 0 0000 0",
               bus.busy_o, bus.done_o, bus.res_o, bus.err_o);
    end
    dn = 0;
    repeat (W + 3) begin
      @(posedge clk);
      #1;
      if (bus.done_o || bus.busy_o) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet activity=%0d exp 0", dn);
    end
    run_op(3'd0, 1'b0, 1'b0, 8'd1, 8'd2, 0,
           r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
    checks++;
    if (r !== 16'h0003 || lat !== 0) begin
      errors++;
      $display("FAIL post_reset_add res=%h lat=%0d exp 0003 0", r, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops[5];
    logic [2:0] op;
    logic s;
    logic [W-1:0] a, b;
    ops = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 8; i++) begin
      op = ops[$urandom_range(0, 4)];
      s = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      model(op, s, a, b, xr, xe);
      last_res = xr;
      @(negedge clk);
      bus.op_i = op; bus.sign_i = s; bus.chain_i = 1'b0;
      bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.done_o !== 1'b1 || bus.res_o !== xr) begin
        errors++;
        $display("FAIL b2b_%0d done=%b res=%h exp 1 %h",
                 i, bus.done_o, bus.res_o, xr);
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic test_random_multi;
    logic [W-1:0] b;
    for (int i = 0; i < 30; i++) begin
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      run_op(3'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
             W'($urandom), b, 0,
             r, e, xr, xe, lat, xlat, bcnt, dcnt, ovl);
      checks++;
      if (r !== xr || e !== xe || lat !== xlat || bcnt !== xlat ||
          dcnt !== 1 || ovl !== 0) begin
        errors++;
        $display("FAIL rand_%0d res=%h err=%b lat=%0d busy=%0d dones=%0d exp %h %b %0d",
                 i, r, e, lat, bcnt, dcnt, xr, xe, xlat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_div_zero();
    test_chain();
    test_reset_mid();
    test_back_to_back();
    test_random_multi();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle arithmetic core for the calculator datapath. It supersedes the fixed 4-bit operand ALU.
- Operand width is configurable.
- Adds iterative multiply, divide and modulo with a busy/done handshake.
- Chain mode reuses the previous result as operand A, replacing external muxing.
- Adds a divide-by-zero error flag.
- Sits between the controller (start/op/chain) and the display path (res_o).

Parameters:
W  8  operand width in bits (W >= 2); result width is 2*W

Ports:
clk      input   1    system clock, all logic on rising edge
rst      input   1    synchronous reset, active-low
start_i  input   1    request operation; sampled only in IDLE
op_i     input   3    0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR
sign_i   input   1    1 = operands two's complement, 0 = unsigned
chain_i  input   1    1 = operand A taken from res_o[W-1:0] instead of a_i
a_i      input   W    operand A
b_i      input   W    operand B
busy_o   output  1    high while a multi-cycle op is in progress
done_o   output  1    one-cycle pulse, res_o/err_o valid and updated
res_o    output  2W   registered result, held until next completed op
err_o    output  1    1 = last completed op was DIV/MOD with B == 0

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; busy_o=0, done_o=0, res_o=0, err_o=0; iteration counter=0. Applies from any state; an in-progress op is abandoned and its result is never written.
- Operand capture, on the accepting edge only:
  - A = chain_i ? res_o[W-1:0] : a_i; B = b_i; op and sign latched.
  - Later input changes do not affect the running op.
- Extension to 2W: sign-extend when sign_i=1, zero-extend when sign_i=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start_i=1 with op in {ADD,SUB,AND,OR,XOR}: result written at the same edge; done_o=1 the following cycle (latency 1); stay IDLE; busy_o stays 0.
  - start_i=1 with op in {MUL,DIV,MOD}: go CALC, counter=0, busy_o=1.
- ADD/SUB: computed at full 2W width on extended operands, so no overflow is possible (e.g. 8-bit unsigned 255+255=510).
- AND/OR/XOR: bitwise on W bits, then extended per sign_i.
- MUL: shift-add on operand magnitudes, one bit per cycle.
- DIV/MOD: restoring division on magnitudes, one quotient bit per cycle.
- CALC: exactly W iterations (counter 0..W-1); on the edge completing iteration W-1, go FIX.
- FIX: one cycle of sign correction, then IDLE. At that edge res_o and err_o are written and done_o=1 for the next cycle. busy_o=0 from that same cycle.
  - MUL latency: start edge to done_o high = W+1 edges.
- Signed rules:
  - Product sign = sign(A) xor sign(B).
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - -2^(W-1) / -1 = +2^(W-1); it fits in 2W bits, no error.
- Divide by zero (B==0, DIV or MOD): still runs the full W+1 latency; err_o=1.
  - DIV: res_o = all ones.
  - MOD: res_o = extended A.
- err_o is cleared by the next completed op with no error, including single-cycle ops.
- start_i while busy_o=1: ignored, not queued.
- start_i held high continuously: a new op is accepted on each IDLE edge. For single-cycle ops this gives back-to-back done_o pulses every cycle.
- done_o is never high in two consecutive cycles for multi-cycle ops.
- done_o and busy_o are never both high.
- Chain after reset: A = 0.

Test Plan:
- W=8, unsigned ADD a=200 b=100 -> next cycle done_o=1, res_o=16'h012C, err_o=0, busy_o never high.
- W=8, signed MUL a=-3 (8'hFD) b=5 -> busy_o high for 9 cycles, done_o on the 9th edge after start, res_o=16'hFFF1.
- W=8, signed DIV a=-7 b=2 -> res_o=16'hFFFD. Repeat with MOD -> res_o=16'hFFFF. Signed DIV a=-128 b=-1 -> res_o=16'h0080, err_o=0.
- W=8, unsigned DIV a=5 b=0 -> err_o=1, res_o=16'hFFFF. MOD same operands -> res_o=16'h0005. Following ADD 1+1 -> err_o=0, res_o=2.
- Chain: ADD 3+4 -> res_o=7. Then chain_i=1, MUL, b=6, a_i=99 -> res_o=16'h002A. Pulse start_i mid-MUL -> ignored, exactly one done_o.
- rst=0 for one cycle during MUL iteration 4 -> outputs zero next cycle, state IDLE, no done_o. A new ADD 1+2 then gives res_o=3.
